// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: assembles big-endian words from a valid/ready
// byte stream and writes them into instruction memory, then frees the CPU.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rx_data/valid/ready incoming byte handshake (transfer on valid & ready)
//   reload              pulse; restarts loading from DONE or ERROR
//   ins_we/addr/data    instruction-memory write port
//   cpu_rst             processor reset, high until the image is loaded
//   load_done/load_err  load completed / aborted
//
// Optional macro LOADER_CSUM_EN adds a trailing XOR checksum byte.
module imem_boot_loader #(
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              ins_we,
    output logic [ADDR_W-1:0] ins_addr,
    output logic [31:0]       ins_data,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_LO, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0]     MAX_N   = 17'(2 ** ADDR_W);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
`ifdef LOADER_CSUM_EN
    localparam state_t S_FIN = S_CSUM;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t            r_state;
    state_t            w_nx;
    logic [15:0]       r_cnt;
    // Only the three earlier bytes are kept; the fourth comes from rx_data.
    logic [23:0]       r_asm;
    logic [1:0]        r_bidx;
    logic [ADDR_W-1:0] r_widx;
    logic [TO_W-1:0]   r_to;
    logic              r_ins_we;
    logic [ADDR_W-1:0] r_ins_addr;
    logic [31:0]       r_ins_data;
    logic              r_cpu_rst;
    logic              r_done;
    logic              r_err;
`ifdef LOADER_CSUM_EN
    logic [7:0]        r_csum;
`endif

    logic        w_acc;
    logic        w_to_hit;
    logic        w_last_w;
    logic [15:0] w_count;
    logic [31:0] w_word;
    logic        w_done_nx;
    logic        w_err_nx;

    assign w_acc    = rx_valid & rx_ready;
    assign w_to_hit = (r_to == TO_LAST);
    assign w_count  = {r_cnt[15:8], rx_data};
    assign w_word   = {r_asm, rx_data};
    assign w_last_w = (16'(r_widx) == r_cnt - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nx;
    end

    always_comb begin
        w_nx = r_state;
        unique case (r_state)
            S_IDLE: if (w_acc) w_nx = S_HDR_LO;
            S_HDR_LO: begin
                if (w_acc) begin
                    if ({1'b0, w_count} > MAX_N) w_nx = S_ERR;
                    else if (w_count == 16'd0)   w_nx = S_FIN;
                    else                         w_nx = S_DATA;
                end else if (w_to_hit) begin
                    w_nx = S_ERR;
                end
            end
            S_DATA: begin
                if (w_acc) begin
                    if (r_bidx == 2'd3 && w_last_w) w_nx = S_FIN;
                end else if (w_to_hit) begin
                    w_nx = S_ERR;
                end
            end
            S_CSUM: begin
`ifdef LOADER_CSUM_EN
                if (w_acc)
                    w_nx = (rx_data == r_csum) ? S_DONE : S_ERR;
                else if (w_to_hit)
                    w_nx = S_ERR;
`else
                w_nx = S_ERR;
`endif
            end
            S_DONE:  if (reload) w_nx = S_IDLE;
            S_ERR:   if (reload) w_nx = S_IDLE;
            default: w_nx = S_IDLE;
        endcase
    end

    // Done/err flags are registered one edge after DONE entry so that the
    // final write strobe has retired before cpu_rst is released.
    always_comb begin
        rx_ready  = 1'b0;
        w_done_nx = (r_state == S_DONE) && !reload;
        w_err_nx  = (w_nx == S_ERR);
        if (!rst)
            rx_ready = (r_state == S_IDLE) || (r_state == S_HDR_LO) ||
                       (r_state == S_DATA) || (r_state == S_CSUM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_asm      <= '0;
            r_bidx     <= '0;
            r_widx     <= '0;
            r_to       <= '0;
            r_ins_we   <= 1'b0;
            r_ins_addr <= '0;
            r_ins_data <= '0;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef LOADER_CSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_ins_we  <= 1'b0;
            r_done    <= w_done_nx;
            r_err     <= w_err_nx;
            r_cpu_rst <= !w_done_nx;
            unique case (r_state)
                S_IDLE: begin
                    r_to   <= '0;
                    r_bidx <= '0;
                    r_widx <= '0;
`ifdef LOADER_CSUM_EN
                    r_csum <= '0;
`endif
                    if (w_acc) r_cnt[15:8] <= rx_data;
                end
                S_HDR_LO: begin
                    if (w_acc) begin
                        r_cnt[7:0] <= rx_data;
                        r_to       <= '0;
                        r_bidx     <= '0;
                        r_widx     <= '0;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_asm  <= w_word[23:0];
                        r_bidx <= r_bidx + 2'd1;
                        r_to   <= '0;
`ifdef LOADER_CSUM_EN
                        r_csum <= r_csum ^ rx_data;
`endif
                        if (r_bidx == 2'd3) begin
                            r_ins_we   <= 1'b1;
                            r_ins_addr <= r_widx;
                            r_ins_data <= w_word;
                            r_widx     <= r_widx + 1'b1;
                        end
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end
                S_CSUM: begin
                    if (w_acc) r_to <= '0;
                    else       r_to <= r_to + 1'b1;
                end
                S_DONE, S_ERR: begin
                    if (reload) begin
                        r_bidx <= '0;
                        r_widx <= '0;
                        r_to   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ins_we    = r_ins_we;
    assign ins_addr  = r_ins_addr;
    assign ins_data  = r_ins_data;
    assign cpu_rst   = r_cpu_rst;
    assign load_done = r_done;
    assign load_err  = r_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: random frames against a
// frame-level parsing model, plus directed boundary scenarios.
module tb_imem_boot_loader;

    localparam int AW  = 10;
    localparam int TO  = 50;
    localparam int TOW = 6;

    logic          clk;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          reload;
    logic          ins_we;
    logic [AW-1:0] ins_addr;
    logic [31:0]   ins_data;
    logic          cpu_rst;
    logic          load_done;
    logic          load_err;

    imem_boot_loader #(
        .ADDR_W(AW), .TIMEOUT_CYCLES(TO), .TO_W(TOW)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .reload(reload),
        .ins_we(ins_we), .ins_addr(ins_addr), .ins_data(ins_data),
        .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] got_a[$];
    logic [31:0]   got_d[$];
    int            got_c[$];
    always @(negedge clk) begin
        if (ins_we === 1'b1) begin
            got_a.push_back(ins_addr);
            got_d.push_back(ins_data);
            got_c.push_back(cyc);
        end
    end

    logic [7:0]    fr[$];
    logic [AW-1:0] ex_a[$];
    logic [31:0]   ex_d[$];
    bit            ex_done;

    // Parse a whole frame the way the image format defines it.
    function automatic void model();
        int n;
        logic [7:0] x;
        ex_a.delete();
        ex_d.delete();
        ex_done = 1'b0;
        n = int'({fr[0], fr[1]});
        if (n > (1 << AW)) return;
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            ex_a.push_back(AW'(i));
            ex_d.push_back({fr[2+4*i], fr[3+4*i], fr[4+4*i], fr[5+4*i]});
            x = x ^ fr[2+4*i] ^ fr[3+4*i] ^ fr[4+4*i] ^ fr[5+4*i];
        end
        ex_done = 1'b1;
`ifdef LOADER_CSUM_EN
        ex_done = (fr[2+4*n] == x);
`endif
    endfunction

    task automatic mk(input int n, input bit bad);
        logic [15:0] nn;
        logic [31:0] w;
        logic [7:0]  x;
        nn = 16'(n);
        x  = 8'h00;
        fr.delete();
        fr.push_back(nn[15:8]);
        fr.push_back(nn[7:0]);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            for (int k = 3; k >= 0; k--) begin
                fr.push_back(w[8*k +: 8]);
                x = x ^ w[8*k +: 8];
            end
        end
`ifdef LOADER_CSUM_EN
        if (bad) x = x ^ 8'($urandom_range(255, 1));
        fr.push_back(x);
`else
        if (bad) x = 8'h00;
`endif
    endtask

    task automatic clr();
        got_a.delete();
        got_d.delete();
        got_c.delete();
    endtask

    task automatic idle(input int g);
        repeat (g) begin
            @(negedge clk);
            rx_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic send_frame(input int gmax);
        foreach (fr[i]) begin
            idle($urandom_range(gmax, 0));
            send(fr[i]);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        reload   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clr();
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({cpu_rst, ins_we, load_done, load_err, rx_ready} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want 10000",
                     {cpu_rst, ins_we, load_done, load_err, rx_ready});
        end
        n_chk++;
        if ({ins_addr, ins_data} !== '0) begin
            n_err++;
            $display("FAIL reset_bus: addr=%h data=%h want 0", ins_addr, ins_data);
        end
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (rx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 1", rx_ready);
        end
        repeat (TO + 10) @(negedge clk);
        n_chk++;
        if ({rx_ready, load_err, cpu_rst} !== 3'b101) begin
            n_err++;
            $display("FAIL idle_no_timeout: ready/err/cpu_rst=%b want 101",
                     {rx_ready, load_err, cpu_rst});
        end
    endtask

    task automatic test_example();
        logic [7:0] x;
        do_reset();
        fr = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05,
               8'hAC, 8'h08, 8'h00, 8'h10};
        x = 8'h00;
        for (int i = 2; i < 10; i++) x = x ^ fr[i];
`ifdef LOADER_CSUM_EN
        fr.push_back(x);
`endif
        model();
        send_frame(0);
        n_chk++;
        if ({load_done, cpu_rst} !== 2'b01) begin
            n_err++;
            $display("FAIL ex_pre_done: done/cpu_rst=%b want 01", {load_done, cpu_rst});
        end
        @(negedge clk);
        n_chk++;
        if ({load_done, cpu_rst, load_err} !== 3'b100) begin
            n_err++;
            $display("FAIL ex_done: done/cpu_rst/err=%b want 100",
                     {load_done, cpu_rst, load_err});
        end
        n_chk++;
        if (got_a.size() != 2) begin
            n_err++;
            $display("FAIL ex_count: writes=%0d want 2", got_a.size());
        end else begin
            n_chk++;
            if (got_a[0] !== 0 || got_d[0] !== 32'h24080005 ||
                got_a[1] !== 1 || got_d[1] !== 32'hAC080010) begin
                n_err++;
                $display("FAIL ex_words: %h@%0d %h@%0d want 24080005@0 AC080010@1",
                         got_d[0], got_a[0], got_d[1], got_a[1]);
            end
        end
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        for (int it = 0; it < 8; it++) begin
            mk($urandom_range(6, 1), ($urandom_range(2, 0) == 0));
            model();
            send_frame(3);
            @(negedge clk);
            n_chk++;
            if ({load_done, load_err, cpu_rst} !== {ex_done, !ex_done, !ex_done}) begin
                n_err++;
                $display("FAIL rnd_status[%0d]: done/err/cpu_rst=%b want %b", it,
                         {load_done, load_err, cpu_rst}, {ex_done, !ex_done, !ex_done});
            end
            bad = 0;
            if (got_a.size() != ex_a.size()) bad = 1;
            else foreach (ex_a[i])
                if (got_a[i] !== ex_a[i] || got_d[i] !== ex_d[i]) bad++;
            n_chk++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL rnd_writes[%0d]: %0d writes, %0d bad, want %0d", it,
                         got_a.size(), bad, ex_a.size());
            end
            do_reload();
            n_chk++;
            if ({load_done, load_err, cpu_rst, rx_ready} !== 4'b0011) begin
                n_err++;
                $display("FAIL rnd_reload[%0d]: done/err/cpu_rst/ready=%b want 0011",
                         it, {load_done, load_err, cpu_rst, rx_ready});
            end
            clr();
        end
    endtask

    task automatic test_oversize();
        do_reset();
        fr = '{8'h04, 8'h01};
        model();
        send_frame(0);
        n_chk++;
        if ({load_err, cpu_rst, rx_ready, load_done} !== 4'b1100) begin
            n_err++;
            $display("FAIL size_err: err/cpu_rst/ready/done=%b want 1100",
                     {load_err, cpu_rst, rx_ready, load_done});
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (got_a.size() != ex_a.size()) begin
            n_err++;
            $display("FAIL size_writes: got %0d want %0d", got_a.size(), ex_a.size());
        end
        do_reload();
        n_chk++;
        if ({load_err, rx_ready, cpu_rst} !== 3'b011) begin
            n_err++;
            $display("FAIL size_reload: err/ready/cpu_rst=%b want 011",
                     {load_err, rx_ready, cpu_rst});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send(8'h00);
        send(8'h01);
        send(8'h12);
        send(8'h34);
        idle(TO - 1);
        @(negedge clk);
        n_chk++;
        if ({rx_ready, load_err} !== 2'b10) begin
            n_err++;
            $display("FAIL to_early: ready/err=%b want 10", {rx_ready, load_err});
        end
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({rx_ready, load_err, cpu_rst} !== 3'b011) begin
            n_err++;
            $display("FAIL to_hit: ready/err/cpu_rst=%b want 011",
                     {rx_ready, load_err, cpu_rst});
        end
        n_chk++;
        if (got_a.size() != 0) begin
            n_err++;
            $display("FAIL to_writes: got %0d want 0", got_a.size());
        end
        do_reset();
        fr = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef LOADER_CSUM_EN
        fr.push_back(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
`endif
        model();
        for (int i = 0; i < 4; i++) send(fr[i]);
        idle(TO - 1);
        for (int i = 4; i < fr.size(); i++) send(fr[i]);
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({load_done, load_err} !== 2'b10 || got_a.size() != 1) begin
            n_err++;
            $display("FAIL to_byte_wins: done/err=%b writes=%0d want 10 1",
                     {load_done, load_err}, got_a.size());
        end else begin
            n_chk++;
            if (got_d[0] !== ex_d[0]) begin
                n_err++;
                $display("FAIL to_byte_data: got %h want %h", got_d[0], ex_d[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        int gap;
        do_reset();
        mk(1 << AW, 1'b0);
        model();
        send_frame(0);
        @(negedge clk);
        n_chk++;
        if ({load_done, cpu_rst, load_err} !== 3'b100) begin
            n_err++;
            $display("FAIL b2b_done: done/cpu_rst/err=%b want 100",
                     {load_done, cpu_rst, load_err});
        end
        n_chk++;
        if (got_a.size() != ex_a.size()) begin
            n_err++;
            $display("FAIL b2b_count: got %0d want %0d", got_a.size(), ex_a.size());
        end else begin
            bad = 0;
            gap = 0;
            foreach (ex_a[i]) begin
                if (got_a[i] !== ex_a[i] || got_d[i] !== ex_d[i]) bad++;
                if (i > 0 && got_c[i] - got_c[i-1] != 4) gap++;
            end
            n_chk++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL b2b_words: %0d wrong, want 0", bad);
            end
            n_chk++;
            if (gap != 0) begin
                n_err++;
                $display("FAIL b2b_spacing: %0d irregular gaps, want 0", gap);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mk(8, 1'b0);
        for (int i = 0; i < 2 + 5 * 4 + 3; i++) send(fr[i]);
        n_chk++;
        if (ins_addr !== AW'(4)) begin
            n_err++;
            $display("FAIL mid_pre: addr=%0d want 4", ins_addr);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({cpu_rst, ins_we, load_done, load_err, rx_ready} !== 5'b10000 ||
            {ins_addr, ins_data} !== '0) begin
            n_err++;
            $display("FAIL mid_reset: ctl=%b addr=%h data=%h want 10000 0 0",
                     {cpu_rst, ins_we, load_done, load_err, rx_ready},
                     ins_addr, ins_data);
        end
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
        clr();
        mk(1, 1'b0);
        model();
        send_frame(1);
        @(negedge clk);
        n_chk++;
        if (got_a.size() != 1 || load_done !== 1'b1) begin
            n_err++;
            $display("FAIL mid_fresh: writes=%0d done=%b want 1 1",
                     got_a.size(), load_done);
        end else begin
            n_chk++;
            if (got_a[0] !== 0 || got_d[0] !== ex_d[0]) begin
                n_err++;
                $display("FAIL mid_word: %h@%0d want %h@0", got_d[0], got_a[0], ex_d[0]);
            end
        end
    endtask

`ifdef LOADER_CSUM_EN
    task automatic test_csum();
        do_reset();
        fr = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
        send_frame(0);
        @(negedge clk);
        n_chk++;
        if ({load_err, load_done, cpu_rst} !== 3'b101) begin
            n_err++;
            $display("FAIL csum_bad: err/done/cpu_rst=%b want 101",
                     {load_err, load_done, cpu_rst});
        end
        do_reload();
        fr[6] = 8'h22;
        send_frame(0);
        @(negedge clk);
        n_chk++;
        if ({load_err, load_done, cpu_rst} !== 3'b010) begin
            n_err++;
            $display("FAIL csum_good: err/done/cpu_rst=%b want 010",
                     {load_err, load_done, cpu_rst});
        end
    endtask
`endif

    initial begin
        #800000;
        $display("FAIL watchdog: time limit hit at cycle %0d, want finish", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_example();
        test_random();
        test_oversize();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
`ifdef LOADER_CSUM_EN
        test_csum();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
